pixel_readout: RTL and testbench

PIXEL_READOUT -- requirements
Module: pixel_readout

---
 rtl/pixel_readout.sv | 161 ++++++++++++++++
 tb/tb_pixel_readout.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout.sv
// Pixel readout capture: orders incoming pixels into frames, tags start/end of
// frame, and buffers {sof, eof, data} words in a small FIFO for a ready/valid sink.
module pixel_readout #(
  parameter int PIXEL_COUNT = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           read,
  input  logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  input  logic [DATA_WIDTH-1:0]          pixel_data,
  input  logic                           clear,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_eof,
  output logic                           overflow,
  output logic                           seq_error,
  output logic [15:0]                    frame_count
);

  localparam int IDX_W = $clog2(PIXEL_COUNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_WIDTH + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   exp_idx, exp_idx_n;

  logic               push_req, push_sof, push_eof;
  logic               seq_ev, ovf_ev, frame_done;
  logic               push_ok, pop;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic [ENT_W-1:0]   head;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      exp_idx <= '0;
    end else begin
      state   <= state_n;
      exp_idx <= exp_idx_n;
    end
  end

  // An out-of-order index 0 in CAPTURE abandons the partial frame and starts a new one.
  always_comb begin
    state_n    = state;
    exp_idx_n  = exp_idx;
    push_req   = 1'b0;
    push_sof   = 1'b0;
    push_eof   = 1'b0;
    seq_ev     = 1'b0;
    frame_done = 1'b0;
    if (read) begin
      unique case (state)
        IDLE: begin
          if (pixel_select == '0) begin
            push_req  = 1'b1;
            push_sof  = 1'b1;
            state_n   = CAPTURE;
            exp_idx_n = IDX_W'(1);
          end else begin
            seq_ev = 1'b1;
          end
        end
        CAPTURE: begin
          if (pixel_select == exp_idx) begin
            push_req = 1'b1;
            if (pixel_select == LAST_IDX) begin
              push_eof   = 1'b1;
              frame_done = 1'b1;
              state_n    = IDLE;
              exp_idx_n  = '0;
            end else begin
              exp_idx_n = exp_idx + IDX_W'(1);
            end
          end else begin
            seq_ev = 1'b1;
            if (pixel_select == '0) begin
              push_req  = 1'b1;
              push_sof  = 1'b1;
              state_n   = CAPTURE;
              exp_idx_n = IDX_W'(1);
            end else begin
              state_n   = IDLE;
              exp_idx_n = '0;
            end
          end
        end
        default: begin
          state_n   = IDLE;
          exp_idx_n = '0;
        end
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push_req && ((count != FULL_CNT) || pop);
  assign ovf_ev    = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_sof, push_eof, pixel_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head     = mem[rd_ptr];
    out_data = '0;
    out_sof  = 1'b0;
    out_eof  = 1'b0;
    if (out_valid) begin
      out_data = head[DATA_WIDTH-1:0];
      out_eof  = head[DATA_WIDTH];
      out_sof  = head[DATA_WIDTH+1];
    end
  end

  // A same-cycle event outranks clear, so no error is lost at the moment of clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow    <= 1'b0;
      seq_error   <= 1'b0;
      frame_count <= '0;
    end else if (clear) begin
      overflow    <= ovf_ev;
      seq_error   <= seq_ev;
      frame_count <= 16'(frame_done);
    end else begin
      if (ovf_ev)     overflow    <= 1'b1;
      if (seq_ev)     seq_error   <= 1'b1;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Scoreboard bench for pixel_readout: stimulus queues expected words, a
// negedge monitor pops and compares each word the DUT hands over.
module tb_pixel_readout;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       read = 1'b0;
  logic [1:0] pixel_select = '0;
  logic [7:0] pixel_data = '0;
  logic       clear = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sof;
  logic       out_eof;
  logic       overflow;
  logic       seq_error;
  logic [15:0] frame_count;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [9:0] q[$];

  pixel_readout #(.PIXEL_COUNT(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .read(read), .pixel_select(pixel_select),
    .pixel_data(pixel_data), .clear(clear), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eof(out_eof), .overflow(overflow), .seq_error(seq_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      logic [9:0] exp_w;
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL word: got %b_%b_%h, none expected", out_sof, out_eof, out_data);
      end else begin
        exp_w = q.pop_front();
        if ({out_sof, out_eof, out_data} !== exp_w) begin
          nerr++;
          $display("FAIL word: got sof=%b eof=%b data=%h, want sof=%b eof=%b data=%h",
                   out_sof, out_eof, out_data, exp_w[9], exp_w[8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp_v);
    end
  endtask

  task automatic pix(input logic [1:0] sel, input logic [7:0] d,
                     input logic push, input logic sof, input logic eof);
    read = 1'b1;
    pixel_select = sel;
    pixel_data = d;
    if (push) q.push_back({sof, eof, d});
    step();
    read = 1'b0;
  endtask

  task automatic idle();
    read = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      step();
    end
    check("drain", 16'(q.size()), 16'd0);
  endtask

  initial begin
    // reset state
    reset = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_seq", 16'(seq_error), 16'd0);
    check("rst_fc", frame_count, 16'd0);
    reset = 1'b1;

    // clean frame, one-cycle latency
    pix(2'd0, 8'h11, 1, 1, 0);
    check("latency_valid", 16'(out_valid), 16'd1);
    pix(2'd1, 8'h22, 1, 0, 0);
    pix(2'd2, 8'h33, 1, 0, 0);
    pix(2'd3, 8'h44, 1, 0, 1);
    idle();
    check("f1_fc", frame_count, 16'd1);
    drain();

    // overflow with stalled sink, then drain in order
    clear = 1'b1; idle(); clear = 1'b0;
    out_ready = 1'b0;
    pix(2'd0, 8'hA0, 1, 1, 0);
    pix(2'd1, 8'hA1, 1, 0, 0);
    pix(2'd2, 8'hA2, 1, 0, 0);
    pix(2'd3, 8'hA3, 1, 0, 1);
    pix(2'd0, 8'hB0, 0, 0, 0);
    idle();
    check("ovf_set", 16'(overflow), 16'd1);
    check("ovf_fc", frame_count, 16'd1);
    check("hold_data", 16'(out_data), 16'h00A0);
    idle();
    check("hold_data2", 16'(out_data), 16'h00A0);
    check("hold_sof", 16'(out_sof), 16'd1);
    out_ready = 1'b1;
    drain();
    pix(2'd1, 8'hB1, 1, 0, 0);
    pix(2'd2, 8'hB2, 1, 0, 0);
    pix(2'd3, 8'hB3, 1, 0, 1);
    idle();
    check("ovf_fc2", frame_count, 16'd2);
    drain();
    clear = 1'b1; idle(); clear = 1'b0;
    check("clr_ovf", 16'(overflow), 16'd0);
    check("clr_fc", frame_count, 16'd0);

    // skipped index abandons frame; clear together with eof leaves count at 1
    pix(2'd0, 8'h50, 1, 1, 0);
    pix(2'd1, 8'h51, 1, 0, 0);
    pix(2'd3, 8'h53, 0, 0, 0);
    check("skip_seq", 16'(seq_error), 16'd1);
    pix(2'd0, 8'h60, 1, 1, 0);
    pix(2'd1, 8'h61, 1, 0, 0);
    pix(2'd2, 8'h62, 1, 0, 0);
    clear = 1'b1;
    pix(2'd3, 8'h63, 1, 0, 1);
    clear = 1'b0;
    check("clr_eof_fc", frame_count, 16'd1);
    check("clr_eof_seq", 16'(seq_error), 16'd0);
    idle();
    drain();

    // restart at index 0 mid-frame
    clear = 1'b1; idle(); clear = 1'b0;
    pix(2'd0, 8'h70, 1, 1, 0);
    pix(2'd1, 8'h71, 1, 0, 0);
    pix(2'd0, 8'h80, 1, 1, 0);
    pix(2'd1, 8'h81, 1, 0, 0);
    pix(2'd2, 8'h82, 1, 0, 0);
    pix(2'd3, 8'h83, 1, 0, 1);
    check("restart_seq", 16'(seq_error), 16'd1);
    check("restart_fc", frame_count, 16'd1);
    idle();
    drain();

    // full FIFO with simultaneous pop and push
    clear = 1'b1; idle(); clear = 1'b0;
    out_ready = 1'b0;
    pix(2'd0, 8'hC0, 1, 1, 0);
    pix(2'd1, 8'hC1, 1, 0, 0);
    pix(2'd2, 8'hC2, 1, 0, 0);
    pix(2'd3, 8'hC3, 1, 0, 1);
    out_ready = 1'b1;
    pix(2'd0, 8'hD0, 1, 1, 0);
    check("popush_ovf", 16'(overflow), 16'd0);
    out_ready = 1'b0;
    pix(2'd1, 8'hD1, 0, 0, 0);
    check("still_full", 16'(overflow), 16'd1);
    idle();
    out_ready = 1'b1;
    drain();

    // reset mid-frame with buffered words
    out_ready = 1'b0;
    pix(2'd0, 8'hE0, 1, 1, 0);
    pix(2'd1, 8'hE1, 1, 0, 0);
    check("pre_rst_valid", 16'(out_valid), 16'd1);
    reset = 1'b0; out_ready = 1'b1;
    idle();
    q.delete();
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_data", {6'd0, out_sof, out_eof, out_data}, 16'd0);
    check("mid_rst_flags", {14'd0, overflow, seq_error}, 16'd0);
    check("mid_rst_fc", frame_count, 16'd0);
    reset = 1'b1;
    pix(2'd2, 8'hF2, 0, 0, 0);
    check("post_rst_seq", 16'(seq_error), 16'd1);
    check("post_rst_valid", 16'(out_valid), 16'd0);

    // error event wins over clear
    clear = 1'b1;
    pix(2'd3, 8'hF3, 0, 0, 0);
    clear = 1'b0;
    check("set_wins", 16'(seq_error), 16'd1);
    pix(2'd0, 8'h01, 1, 1, 0);
    pix(2'd1, 8'h02, 1, 0, 0);
    pix(2'd2, 8'h03, 1, 0, 0);
    pix(2'd3, 8'h04, 1, 0, 1);
    idle();
    check("final_fc", frame_count, 16'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
